// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger game controller: state encodings,
// default freeze lengths and the bonus-life score rule.
package frogger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int DEF_DEATH_FRAMES = 60;
    localparam int DEF_GOAL_FRAMES  = 30;
    localparam int MAX_LIVES        = 3;

    // A bonus life is earned on every nonzero multiple of ten points.
    function automatic logic bonus_score(input logic [6:0] score);
        return (score != 7'd0) && ((score % 7'd10) == 7'd0);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchronizer plus single-cycle edge pulse (rising or falling,
// selected by c_FALLING).
module edge_detect #(
    parameter bit c_FALLING = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Edge
);

    logic q1;
    logic q2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= i_Sig;
            q2 <= q1;
        end
    end

    assign o_Edge = c_FALLING ? (q2 & ~q1) : (q1 & ~q2);

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game flow controller: lives, score, freeze timing and respawn.
// Define GAME_EXTRA_LIFE_EN to award a life on every tenth point.
module game_state_ctrl
    import frogger_pkg::*;
#(
    parameter int c_LIVES        = 3,
    parameter int c_SCORE_LIMIT  = 99,
    parameter int c_DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int c_GOAL_FRAMES  = DEF_GOAL_FRAMES,
    parameter int c_GOAL_ROW     = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Game_Active,
    output logic       o_Frogger_Respawn,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_State
);

    localparam int MAX_FRAMES = (c_DEATH_FRAMES > c_GOAL_FRAMES) ? c_DEATH_FRAMES : c_GOAL_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    state_t           state, state_n;
    logic [1:0]       lives, lives_n;
    logic [6:0]       score, score_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             respawn, respawn_n;
    logic             start_req;
    logic             tick;

    edge_detect #(.c_FALLING(1'b0)) u_start_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Game_Start),
        .o_Edge  (start_req)
    );

    edge_detect #(.c_FALLING(1'b1)) u_vsync_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_VSync),
        .o_Edge  (tick)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= ST_IDLE;
            lives   <= 2'd0;
            score   <= 7'd0;
            cnt     <= '0;
            respawn <= 1'b0;
        end else begin
            state   <= state_n;
            lives   <= lives_n;
            score   <= score_n;
            cnt     <= cnt_n;
            respawn <= respawn_n;
        end
    end

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        score_n   = score;
        cnt_n     = cnt;
        respawn_n = 1'b0;
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_req) begin
                    lives_n   = 2'(c_LIVES);
                    score_n   = 7'd0;
                    respawn_n = 1'b1;
                    state_n   = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // Collision outranks a goal seen in the same cycle.
                if (i_Collided) begin
                    if (lives != 2'd0)
                        lives_n = lives - 2'd1;
                    cnt_n   = '0;
                    state_n = ST_DYING;
                end else if (i_Frogger_Y == 6'(c_GOAL_ROW)) begin
                    if (score < 7'(c_SCORE_LIMIT))
                        score_n = score + 7'd1;
`ifdef GAME_EXTRA_LIFE_EN
                    if (bonus_score(score_n) && (lives < 2'(MAX_LIVES)))
                        lives_n = lives + 2'd1;
`endif
                    cnt_n   = '0;
                    state_n = ST_SCORED;
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (cnt == CNT_W'(c_DEATH_FRAMES - 1)) begin
                        if (lives == 2'd0) begin
                            state_n = ST_GAME_OVER;
                        end else begin
                            respawn_n = 1'b1;
                            state_n   = ST_RUNNING;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ST_SCORED: begin
                if (tick) begin
                    if (cnt == CNT_W'(c_GOAL_FRAMES - 1)) begin
                        if (score == 7'(c_SCORE_LIMIT)) begin
                            state_n = ST_GAME_OVER;
                        end else begin
                            respawn_n = 1'b1;
                            state_n   = ST_RUNNING;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_Game_Active     = (state == ST_RUNNING);
    assign o_Frogger_Respawn = respawn;
    assign o_Lives           = lives;
    assign o_Score           = score;
    assign o_State           = state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus random
// play against a game-level model (lives, score, phase).
module tb_game_state_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_VSync = 1'b0;
    logic       i_Game_Start = 1'b0;
    logic       i_Collided = 1'b0;
    logic [5:0] i_Frogger_Y = 6'd20;
    logic       o_Game_Active;
    logic       o_Frogger_Respawn;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [2:0] o_State;

    localparam int DEATH = 60;
    localparam int GOAL  = 30;
    localparam int LIMIT = 99;

    // Phase numbers as the outside world sees them on o_State.
    localparam int P_IDLE = 0, P_RUN = 1, P_DYING = 2, P_SCORED = 3, P_OVER = 4;

    int n_pass  = 0;
    int n_total = 0;
    int resp_cnt = 0;
    int m_lives;
    int m_score;
    int base;

    game_state_ctrl dut (
        .i_Clk             (i_Clk),
        .i_Rst_L           (i_Rst_L),
        .i_VSync           (i_VSync),
        .i_Game_Start      (i_Game_Start),
        .i_Collided        (i_Collided),
        .i_Frogger_Y       (i_Frogger_Y),
        .o_Game_Active     (o_Game_Active),
        .o_Frogger_Respawn (o_Frogger_Respawn),
        .o_Lives           (o_Lives),
        .o_Score           (o_Score),
        .o_State           (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) if (o_Frogger_Respawn) resp_cnt++;

    task automatic idle(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            i_VSync = 1'b1;
            idle(2);
            i_VSync = 1'b0;
            idle(2);
        end
    endtask

    task automatic press_start();
        i_Game_Start = 1'b1;
        idle(3);
        i_Game_Start = 1'b0;
        idle(2);
    endtask

    task automatic collide();
        i_Collided = 1'b1;
        idle(1);
        i_Collided = 1'b0;
    endtask

    task automatic goal();
        i_Frogger_Y = 6'd0;
        idle(1);
        i_Frogger_Y = 6'($urandom_range(63, 1));
    endtask

    task automatic hard_reset();
        i_Rst_L = 1'b0;
        idle(3);
        i_Rst_L = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        idle(2);
        i_Rst_L = 1'b1;
        idle(2);
        #2 i_Rst_L = 1'b0;
        #1;
        n_total++;
        if ({o_State, o_Lives, o_Score, o_Game_Active, o_Frogger_Respawn} !== 14'd0)
            $display("FAIL reset_outputs state=%0d lives=%0d score=%0d act=%b resp=%b want all zero",
                     o_State, o_Lives, o_Score, o_Game_Active, o_Frogger_Respawn);
        else n_pass++;
        idle(2);
        i_Rst_L = 1'b1;
        idle(2);
    endtask

    task automatic test_start();
        base = resp_cnt;
        i_Game_Start = 1'b1;
        idle(2);
        n_total++;
        if (o_State !== 3'(P_RUN) || o_Frogger_Respawn !== 1'b1 || o_Lives !== 2'd3 || o_Score !== 7'd0)
            $display("FAIL start_2cyc state=%0d resp=%b lives=%0d score=%0d want 1 1 3 0",
                     o_State, o_Frogger_Respawn, o_Lives, o_Score);
        else n_pass++;
        idle(20);
        n_total++;
        if (resp_cnt - base != 1 || o_Game_Active !== 1'b1)
            $display("FAIL start_held respawns=%0d active=%b want 1 1", resp_cnt - base, o_Game_Active);
        else n_pass++;
        i_Game_Start = 1'b0;
        idle(2);
        m_lives = 3;
        m_score = 0;
    endtask

    task automatic test_collision();
        collide();
        m_lives--;
        n_total++;
        if (o_State !== 3'(P_DYING) || o_Lives !== 2'(m_lives) || o_Game_Active !== 1'b0)
            $display("FAIL collide state=%0d lives=%0d act=%b want 2 %0d 0", o_State, o_Lives, o_Game_Active, m_lives);
        else n_pass++;
        base = resp_cnt;
        // While frozen, collisions, goal rows and restart presses must be ignored.
        i_Collided = 1'b1;
        i_Frogger_Y = 6'd0;
        ticks(DEATH - 1);
        press_start();
        idle(200);
        i_Collided = 1'b0;
        i_Frogger_Y = 6'd20;
        n_total++;
        if (o_State !== 3'(P_DYING) || o_Lives !== 2'(m_lives) || o_Score !== 7'(m_score) || resp_cnt != base)
            $display("FAIL dying_hold state=%0d lives=%0d score=%0d respawns=%0d want 2 %0d %0d 0",
                     o_State, o_Lives, o_Score, resp_cnt - base, m_lives, m_score);
        else n_pass++;
        ticks(1);
        idle(1);
        n_total++;
        if (o_State !== 3'(P_RUN) || resp_cnt - base != 1)
            $display("FAIL dying_exit state=%0d respawns=%0d want 1 1", o_State, resp_cnt - base);
        else n_pass++;
    endtask

    task automatic test_game_over();
        while (m_lives > 0) begin
            collide();
            m_lives--;
            base = resp_cnt;
            ticks(DEATH);
            idle(1);
        end
        n_total++;
        if (o_State !== 3'(P_OVER) || o_Lives !== 2'd0 || resp_cnt != base || o_Game_Active !== 1'b0)
            $display("FAIL game_over state=%0d lives=%0d respawns=%0d want 4 0 0", o_State, o_Lives, resp_cnt - base);
        else n_pass++;
        press_start();
        m_lives = 3;
        m_score = 0;
        n_total++;
        if (o_State !== 3'(P_RUN) || o_Lives !== 2'd3 || o_Score !== 7'd0)
            $display("FAIL restart state=%0d lives=%0d score=%0d want 1 3 0", o_State, o_Lives, o_Score);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        i_Collided = 1'b1;
        i_Frogger_Y = 6'd0;
        idle(1);
        i_Collided = 1'b0;
        i_Frogger_Y = 6'd20;
        m_lives--;
        n_total++;
        if (o_State !== 3'(P_DYING) || o_Score !== 7'(m_score) || o_Lives !== 2'(m_lives))
            $display("FAIL simultaneous state=%0d score=%0d lives=%0d want 2 %0d %0d", o_State, o_Score, o_Lives, m_score, m_lives);
        else n_pass++;
        ticks(DEATH);
        idle(1);
    endtask

    // Random play: the model tracks lives/score and the expected phase after
    // each event purely from the game rules.
    task automatic test_random_play();
        int exp_phase;
        for (int ev = 0; ev < 24; ev++) begin
            base = resp_cnt;
            if ($urandom_range(3, 0) == 0) begin
                collide();
                if (m_lives > 0) m_lives--;
                ticks(DEATH);
                exp_phase = (m_lives == 0) ? P_OVER : P_RUN;
            end else begin
                goal();
                if (m_score < LIMIT) m_score++;
`ifdef GAME_EXTRA_LIFE_EN
                if (m_score % 10 == 0 && m_lives < 3) m_lives++;
`endif
                ticks(GOAL);
                exp_phase = (m_score == LIMIT) ? P_OVER : P_RUN;
            end
            idle(1);
            n_total++;
            if (o_State !== 3'(exp_phase) || o_Lives !== 2'(m_lives) || o_Score !== 7'(m_score) ||
                resp_cnt - base != ((exp_phase == P_RUN) ? 1 : 0))
                $display("FAIL random_ev%0d state=%0d lives=%0d score=%0d resp=%0d want %0d %0d %0d",
                         ev, o_State, o_Lives, o_Score, resp_cnt - base, exp_phase, m_lives, m_score);
            else n_pass++;
            if (exp_phase == P_OVER) begin
                press_start();
                m_lives = 3;
                m_score = 0;
            end
            i_Frogger_Y = 6'($urandom_range(63, 1));
            ticks($urandom_range(3, 0));
        end
    endtask

    task automatic test_score_limit();
        hard_reset();
        press_start();
        m_score = 0;
        while (m_score < LIMIT - 1) begin
            goal();
            m_score++;
            ticks(GOAL);
        end
        n_total++;
        if (o_Score !== 7'(LIMIT - 1) || o_State !== 3'(P_RUN))
            $display("FAIL preset_98 score=%0d state=%0d want 98 1", o_Score, o_State);
        else n_pass++;
        goal();
        ticks(GOAL);
        idle(1);
        n_total++;
        if (o_Score !== 7'(LIMIT) || o_State !== 3'(P_OVER))
            $display("FAIL score_limit score=%0d state=%0d want 99 4", o_Score, o_State);
        else n_pass++;
        goal();
        ticks(GOAL);
        n_total++;
        if (o_Score !== 7'(LIMIT) || o_State !== 3'(P_OVER))
            $display("FAIL no_wrap score=%0d state=%0d want 99 4", o_Score, o_State);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dying();
        press_start();
        collide();
        ticks(30);
        #2 i_Rst_L = 1'b0;
        #1;
        n_total++;
        if ({o_State, o_Lives, o_Score, o_Game_Active, o_Frogger_Respawn} !== 14'd0)
            $display("FAIL reset_mid_dying state=%0d lives=%0d score=%0d act=%b resp=%b want all zero",
                     o_State, o_Lives, o_Score, o_Game_Active, o_Frogger_Respawn);
        else n_pass++;
        idle(3);
        i_Rst_L = 1'b1;
        base = resp_cnt;
        ticks(40);
        idle(1);
        n_total++;
        if (o_State !== 3'(P_IDLE) || resp_cnt != base)
            $display("FAIL post_reset state=%0d respawns=%0d want 0 0", o_State, resp_cnt - base);
        else n_pass++;
        press_start();
        n_total++;
        if (o_State !== 3'(P_RUN) || o_Lives !== 2'd3 || o_Score !== 7'd0 || resp_cnt - base != 1)
            $display("FAIL start_after_reset state=%0d lives=%0d score=%0d resp=%0d want 1 3 0 1",
                     o_State, o_Lives, o_Score, resp_cnt - base);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_collision();
        test_game_over();
        test_simultaneous();
        test_random_play();
        test_score_limit();
        test_reset_mid_dying();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
